// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM encoding, palette and default screen geometry.
// The geometry defaults are also used by the CRT controller's top level.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      MISS = 2'd2
   } state_t;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b001;

   localparam int DEF_XRES        = 640;
   localparam int DEF_YRES        = 480;
   localparam int DEF_BALL        = 8;
   localparam int DEF_STEP        = 4;
   localparam int DEF_PADDLE_X    = 16;
   localparam int DEF_PADDLE_W    = 8;
   localparam int DEF_PADDLE_H    = 64;
   localparam int DEF_PADDLE_STEP = 8;
   localparam int DEF_MISS_FRAMES = 60;

endpackage

// File: rtl/pong_frame_tick.sv
// Frame tick: one-clock pulse on each falling edge of the active-low vsync.
// vsync_q resets high so no tick appears until a genuine falling edge.
module pong_frame_tick (
   input  logic clock,
   input  logic reset,
   input  logic vsync,
   output logic tick
);

   logic vsync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) vsync_q <= 1'b1;
      else       vsync_q <= vsync;
   end

   assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/pong_ball_renderer.sv
// Pong game state (ball, paddle, score) advanced once per frame,
// plus the registered per-pixel colour lookup.
module pong_ball_renderer
   import pong_pkg::*;
#(
   parameter int XRES        = DEF_XRES,
   parameter int YRES        = DEF_YRES,
   parameter int BALL        = DEF_BALL,
   parameter int STEP        = DEF_STEP,
   parameter int PADDLE_X    = DEF_PADDLE_X,
   parameter int PADDLE_W    = DEF_PADDLE_W,
   parameter int PADDLE_H    = DEF_PADDLE_H,
   parameter int PADDLE_STEP = DEF_PADDLE_STEP,
   parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] xpos,
   input  logic [9:0] ypos,
   input  logic       vsync,
   input  logic       serve,
   input  logic       paddle_up,
   input  logic       paddle_down,
   output logic [2:0] rgb,
   output logic [3:0] hits,
   output logic [3:0] misses,
   output logic       playing
);

   localparam logic [10:0] XR = 11'(XRES);
   localparam logic [10:0] YR = 11'(YRES);
   localparam logic [10:0] BS = 11'(BALL);
   localparam logic [10:0] PX = 11'(PADDLE_X);
   localparam logic [10:0] PE = 11'(PADDLE_X + PADDLE_W);
   localparam logic [10:0] PH = 11'(PADDLE_H);

   localparam logic signed [10:0] ST   = 11'(STEP);
   localparam logic signed [10:0] XMAX = 11'(XRES - BALL);
   localparam logic signed [10:0] YMAX = 11'(YRES - BALL);
   localparam logic signed [10:0] PES  = 11'(PADDLE_X + PADDLE_W);

   localparam logic [9:0] CX    = 10'((XRES - BALL) / 2);
   localparam logic [9:0] CY    = 10'((YRES - BALL) / 2);
   localparam logic [9:0] PY0   = 10'((YRES - PADDLE_H) / 2);
   localparam logic [9:0] PMAX  = 10'(YRES - PADDLE_H);
   localparam logic [9:0] PSTEP = 10'(PADDLE_STEP);

   localparam int TW = $clog2(MISS_FRAMES);
   localparam logic [TW-1:0] TLAST = TW'(MISS_FRAMES - 1);

   state_t             state;
   logic [9:0]         ball_x, ball_y, paddle_y, pad_next;
   logic               dx, dy, tick, hit;
   logic [TW-1:0]      miss_timer;
   logic signed [10:0] sx, sy, nx, ny;
   logic [10:0]        px, py, bx, by, pdy;
   logic               in_ball, in_pad, off;

   pong_frame_tick u_tick (
      .clock (clock),
      .reset (reset),
      .vsync (vsync),
      .tick  (tick)
   );

   assign sx = $signed({1'b0, ball_x});
   assign sy = $signed({1'b0, ball_y});
   assign nx = dx ? sx + ST : sx - ST;
   assign ny = dy ? sy + ST : sy - ST;

   assign px  = {1'b0, xpos};
   assign py  = {1'b0, ypos};
   assign bx  = {1'b0, ball_x};
   assign by  = {1'b0, ball_y};
   assign pdy = {1'b0, paddle_y};

   // Overlap uses the pre-tick ball and paddle positions.
   assign hit = !dx && (nx <= PES) && (bx >= PE) &&
                (by + BS > pdy) && (by < pdy + PH);

   always_comb begin
      pad_next = paddle_y;
      if (paddle_up && !paddle_down)
         pad_next = (paddle_y < PSTEP) ? 10'd0 : paddle_y - PSTEP;
      else if (paddle_down && !paddle_up)
         pad_next = (paddle_y > PMAX - PSTEP) ? PMAX : paddle_y + PSTEP;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ball_x     <= CX;
         ball_y     <= CY;
         dx         <= 1'b1;
         dy         <= 1'b1;
         paddle_y   <= PY0;
         miss_timer <= '0;
         hits       <= '0;
         misses     <= '0;
         playing    <= 1'b0;
      end else if (tick) begin
         paddle_y <= pad_next;
         unique case (state)
            IDLE: begin
               ball_x <= CX;
               ball_y <= CY;
               if (serve) begin
                  state   <= PLAY;
                  playing <= 1'b1;
                  dx      <= 1'b1;
                  dy      <= 1'b1;
                  ball_x  <= CX + 10'(STEP);
                  ball_y  <= CY + 10'(STEP);
               end
            end
            PLAY: begin
               if (ny < 0) begin
                  ball_y <= 10'd0;
                  dy     <= 1'b1;
               end else if (ny > YMAX) begin
                  ball_y <= YMAX[9:0];
                  dy     <= 1'b0;
               end else begin
                  ball_y <= ny[9:0];
               end
               if (dx) begin
                  if (nx > XMAX) begin
                     ball_x <= XMAX[9:0];
                     dx     <= 1'b0;
                  end else begin
                     ball_x <= nx[9:0];
                  end
               end else if (hit) begin
                  ball_x <= PE[9:0];
                  dx     <= 1'b1;
                  if (hits != 4'hF) hits <= hits + 4'd1;
               end else if (nx < 0) begin
                  // Ball freezes where it left the field.
                  state      <= MISS;
                  playing    <= 1'b0;
                  miss_timer <= '0;
                  ball_y     <= ball_y;
                  if (misses != 4'hF) misses <= misses + 4'd1;
               end else begin
                  ball_x <= nx[9:0];
               end
            end
            MISS: begin
               if (miss_timer == TLAST) begin
                  state  <= IDLE;
                  ball_x <= CX;
                  ball_y <= CY;
               end else begin
                  miss_timer <= miss_timer + TW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               playing <= 1'b0;
            end
         endcase
      end
   end

   assign off     = (px >= XR) || (py >= YR);
   assign in_ball = (px >= bx) && (px < bx + BS) &&
                    (py >= by) && (py < by + BS);
   assign in_pad  = (px >= PX) && (px < PE) &&
                    (py >= pdy) && (py < pdy + PH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          rgb <= BLACK;
      else if (off)                       rgb <= BLACK;
      else if (in_ball && state != MISS)  rgb <= WHITE;
      else if (in_pad)                    rgb <= GREEN;
      else                                rgb <= BLUE;
   end

endmodule

// File: tb/tb_pong_ball_renderer.sv
// Directed bench for pong_ball_renderer: reset, paddle clamps, serve,
// wall/paddle reflections, miss timeout and mid-play reset.
module tb_pong_ball_renderer;

   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] xpos, ypos;
   logic       vsync, serve, paddle_up, paddle_down;
   logic [2:0] rgb;
   logic [3:0] hits, misses;
   logic       playing;

   int checks = 0;
   int fails  = 0;
   int k      = 0;
   logic [2:0] c;

   always #5 clock = ~clock;

   pong_ball_renderer dut (
      .clock       (clock),
      .reset       (reset),
      .xpos        (xpos),
      .ypos        (ypos),
      .vsync       (vsync),
      .serve       (serve),
      .paddle_up   (paddle_up),
      .paddle_down (paddle_down),
      .rgb         (rgb),
      .hits        (hits),
      .misses      (misses),
      .playing     (playing)
   );

   task automatic pix(input int x, input int y, output logic [2:0] col);
      @(negedge clock);
      xpos = 10'(x);
      ypos = 10'(y);
      @(posedge clock);
      #1 col = rgb;
   endtask

   // vsync low for 1..3 clocks: still exactly one tick per frame
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         vsync = 1'b0;
         repeat (1 + (k % 3)) @(negedge clock);
         vsync = 1'b1;
         k++;
         repeat (2) @(negedge clock);
      end
   endtask

   task automatic test_reset;
      int px[8] = '{316, 323, 315, 324, 20, 700, 100, 100};
      int py[8] = '{236, 243, 236, 243, 210, 236, 100, 480};
      logic [2:0] ex[8] = '{3'd7, 3'd7, 3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0};
      reset = 1'b1; vsync = 1'b1; serve = 1'b0;
      paddle_up = 1'b0; paddle_down = 1'b0;
      xpos = '0; ypos = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pix(px[i], py[i], c);
         checks++;
         if (c !== ex[i]) begin
            fails++;
            $display("FAIL reset_pixel (%0d,%0d): rgb=%0d want %0d",
                     px[i], py[i], c, ex[i]);
         end
      end
      checks++;
      if ({hits, misses, playing} !== 9'd0) begin
         fails++;
         $display("FAIL reset_outputs: hits=%0d misses=%0d playing=%0d want 0",
                  hits, misses, playing);
      end
   endtask

   task automatic test_paddle;
      int px[10] = '{16, 16, 16, 16, 16, 23, 16, 16, 20, 20};
      int py[10] = '{0, 63, 64, 0, 415, 479, 416, 415, 210, 207};
      logic [2:0] ex[10] = '{2, 2, 1, 2, 1, 2, 2, 1, 2, 1};
      paddle_up = 1'b1;
      frames(26);
      for (int i = 0; i < 3; i++) begin
         pix(px[i], py[i], c);
         checks++;
         if (c !== ex[i]) begin
            fails++;
            $display("FAIL paddle_top (%0d,%0d): rgb=%0d want %0d",
                     px[i], py[i], c, ex[i]);
         end
      end
      frames(1);
      paddle_down = 1'b1;
      frames(1);
      paddle_up = 1'b0;
      pix(px[3], py[3], c);
      checks++;
      if (c !== ex[3]) begin
         fails++;
         $display("FAIL paddle_clamp0: rgb=%0d want %0d", c, ex[3]);
      end
      frames(53);
      for (int i = 4; i < 8; i++) begin
         pix(px[i], py[i], c);
         checks++;
         if (c !== ex[i]) begin
            fails++;
            $display("FAIL paddle_bottom (%0d,%0d): rgb=%0d want %0d",
                     px[i], py[i], c, ex[i]);
         end
      end
      paddle_down = 1'b0;
      paddle_up = 1'b1;
      frames(26);
      paddle_up = 1'b0;
      for (int i = 8; i < 10; i++) begin
         pix(px[i], py[i], c);
         checks++;
         if (c !== ex[i]) begin
            fails++;
            $display("FAIL paddle_centre (%0d,%0d): rgb=%0d want %0d",
                     px[i], py[i], c, ex[i]);
         end
      end
      checks++;
      if (playing !== 1'b0) begin
         fails++;
         $display("FAIL idle_playing: playing=%0d want 0", playing);
      end
   endtask

   task automatic test_serve;
      int bx[2] = '{320, 324};
      int by[2] = '{240, 244};
      serve = 1'b1;
      k = 0;
      for (int s = 0; s < 2; s++) begin
         frames(1);
         checks++;
         if (playing !== 1'b1) begin
            fails++;
            $display("FAIL serve_playing tick %0d: playing=%0d want 1",
                     k, playing);
         end
         for (int i = 0; i < 2; i++) begin
            pix(bx[s] + 7 * i, by[s] + 7 * i, c);
            checks++;
            if (c !== 3'd7) begin
               fails++;
               $display("FAIL serve_ball tick %0d (%0d,%0d): rgb=%0d want 7",
                        k, bx[s] + 7 * i, by[s] + 7 * i, c);
            end
         end
      end
      serve = 1'b0;
   endtask

   task automatic test_bounce_bottom;
      int at[3] = '{59, 60, 61};
      int bx[3] = '{552, 556, 560};
      int by[3] = '{472, 472, 468};
      for (int s = 0; s < 3; s++) begin
         frames(at[s] - k);
         for (int i = 0; i < 2; i++) begin
            pix(bx[s] + 7 * i, by[s] + 7 * i, c);
            checks++;
            if (c !== 3'd7) begin
               fails++;
               $display("FAIL bottom_ball tick %0d (%0d,%0d): rgb=%0d want 7",
                        k, bx[s] + 7 * i, by[s] + 7 * i, c);
            end
         end
      end
   endtask

   task automatic test_paddle_hit;
      int at[3] = '{231, 232, 233};
      int bx[3] = '{28, 24, 28};
      int by[3] = '{208, 212, 216};
      logic [3:0] eh[3] = '{0, 1, 1};
      for (int s = 0; s < 3; s++) begin
         frames(at[s] - k);
         checks++;
         if (hits !== eh[s]) begin
            fails++;
            $display("FAIL hit_count tick %0d: hits=%0d want %0d",
                     k, hits, eh[s]);
         end
         for (int i = 0; i < 2; i++) begin
            pix(bx[s] + 7 * i, by[s] + 7 * i, c);
            checks++;
            if (c !== 3'd7) begin
               fails++;
               $display("FAIL hit_ball tick %0d (%0d,%0d): rgb=%0d want 7",
                        k, bx[s] + 7 * i, by[s] + 7 * i, c);
            end
         end
      end
   endtask

   task automatic test_miss;
      paddle_up = 1'b1;
      frames(543 - k);
      for (int i = 0; i < 2; i++) begin
         pix(7 * i, 444 + 7 * i, c);
         checks++;
         if (c !== 3'd7) begin
            fails++;
            $display("FAIL pre_miss_ball (%0d,%0d): rgb=%0d want 7",
                     7 * i, 444 + 7 * i, c);
         end
      end
      checks++;
      if ({playing, misses} !== 5'b1_0000) begin
         fails++;
         $display("FAIL pre_miss_state: playing=%0d misses=%0d want 1 0",
                  playing, misses);
      end
      frames(1);
      checks++;
      if ({playing, misses, hits} !== 9'b0_0001_0001) begin
         fails++;
         $display("FAIL miss_state: playing=%0d misses=%0d hits=%0d want 0 1 1",
                  playing, misses, hits);
      end
      pix(0, 444, c);
      checks++;
      if (c !== 3'd1) begin
         fails++;
         $display("FAIL miss_hidden: rgb=%0d want 1", c);
      end
      frames(59);
      pix(316, 236, c);
      checks++;
      if (c !== 3'd1) begin
         fails++;
         $display("FAIL miss_59_centre: rgb=%0d want 1", c);
      end
      pix(0, 444, c);
      checks++;
      if (c !== 3'd1) begin
         fails++;
         $display("FAIL miss_59_frozen: rgb=%0d want 1", c);
      end
      frames(1);
      pix(316, 236, c);
      checks++;
      if (c !== 3'd7) begin
         fails++;
         $display("FAIL idle_centre: rgb=%0d want 7", c);
      end
      pix(324, 236, c);
      checks++;
      if (c !== 3'd1) begin
         fails++;
         $display("FAIL idle_centre_edge: rgb=%0d want 1", c);
      end
      checks++;
      if ({playing, misses} !== 5'b0_0001) begin
         fails++;
         $display("FAIL idle_state: playing=%0d misses=%0d want 0 1",
                  playing, misses);
      end
      paddle_up = 1'b0;
   endtask

   task automatic test_reset_mid_play;
      serve = 1'b1;
      frames(3);
      checks++;
      if (playing !== 1'b1) begin
         fails++;
         $display("FAIL replay_playing: playing=%0d want 1", playing);
      end
      pix(100, 100, c);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({rgb, hits, misses, playing} !== 12'd0) begin
         fails++;
         $display("FAIL async_reset: rgb=%0d hits=%0d misses=%0d playing=%0d want 0",
                  rgb, hits, misses, playing);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checks++;
      if (playing !== 1'b0) begin
         fails++;
         $display("FAIL no_tick_after_reset: playing=%0d want 0", playing);
      end
      pix(316, 236, c);
      checks++;
      if (c !== 3'd7) begin
         fails++;
         $display("FAIL post_reset_centre: rgb=%0d want 7", c);
      end
      frames(1);
      checks++;
      if (playing !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_serve: playing=%0d want 1", playing);
      end
      for (int i = 0; i < 2; i++) begin
         pix(320 + 7 * i, 240 + 7 * i, c);
         checks++;
         if (c !== 3'd7) begin
            fails++;
            $display("FAIL post_reset_ball (%0d,%0d): rgb=%0d want 7",
                     320 + 7 * i, 240 + 7 * i, c);
         end
      end
      serve = 1'b0;
   endtask

   initial begin
      test_reset();
      test_paddle();
      test_serve();
      test_bounce_bottom();
      test_paddle_hit();
      test_miss();
      test_reset_mid_play();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
